// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared types and constants for the BRAM read streamer
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rs_state_t;

    // Output buffer depth; also the number of read credits available.
    localparam int RS_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo2_reg.sv
// rtl/fifo2_reg.sv - 2-entry register FIFO, head word driven straight from a register
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write one entry
//   pop           remove the head entry (ignored when empty)
//   dout          head entry (registered, no bypass from din)
//   count         number of stored entries, 0..2
module fifo2_reg
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign dout   = entry0;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= din;
                        count  <= 2'd1;
                    end else if (count == 2'd1) begin
                        entry1 <= din;
                        count  <= 2'(RS_BUF_DEPTH);
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_read_stream.sv
// rtl/bram_read_stream.sv - sequential BRAM reader presenting words as a valid/ready stream
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, base, len    burst request, sampled only in IDLE
//   busy, done          burst in progress / one-cycle end-of-burst pulse
//   mem_addr, mem_data  RAM read port (1-cycle read latency)
//   out_data, out_valid, out_ready, out_last   output stream
module bram_read_stream
    import bram_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int LENW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base,
    input  logic [LENW-1:0]  len,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    rs_state_t        state;
    rs_state_t        state_next;
    logic [LENW-1:0]  burst_len;
    logic [LENW-1:0]  issue_cnt;
    logic             inflight;
    logic             inflight_last;
    logic [1:0]       fifo_count;
    logic [WIDTH:0]   fifo_dout;
    logic             pop;
    logic [2:0]       occupancy;
    logic             credit_ok;
    logic             issue;
    logic             last_issue;
    logic             accept;
    logic [ADDRW-1:0] next_addr;

    fifo2_reg #(
        .WIDTH(WIDTH + 1)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   ({inflight_last, mem_data}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_dout[WIDTH-1:0];
    assign out_last  = out_valid && fifo_dout[WIDTH];
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // Every word either buffered or still coming out of the RAM holds a credit;
    // a pop this cycle frees one in time for the word issued now.
    assign occupancy  = 3'(fifo_count) + 3'(inflight);
    assign credit_ok  = (occupancy - 3'(pop)) < 3'(RS_BUF_DEPTH);
    assign issue      = (state == READ) && credit_ok;
    assign last_issue = issue && (issue_cnt == burst_len - LENW'(1));
    assign accept     = (state == IDLE) && start && (len != '0);
    assign next_addr  = (mem_addr == ADDRW'(DEPTH - 1)) ? '0 : mem_addr + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)          state_next = READ;
            READ:    if (last_issue)      state_next = DRAIN;
            DRAIN:   if (pop && out_last) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem_addr      <= '0;
            burst_len     <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= issue;
            inflight_last <= last_issue;
            // A zero-length request completes immediately without touching the RAM.
            done          <= ((state == IDLE) && start && (len == '0))
                          || ((state == DRAIN) && pop && out_last);
            if (accept) begin
                mem_addr  <= base;
                burst_len <= len;
                issue_cnt <= '0;
            end else if (issue) begin
                mem_addr  <= next_addr;
                issue_cnt <= issue_cnt + LENW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bram_read_stream.sv
// tb/tb_bram_read_stream.sv - randomized self-checking bench for bram_read_stream
module tb_bram_read_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int ADDRW = 8;
    localparam int LENW  = 9;

    logic             clk;
    logic             rst;
    logic             start;
    logic [ADDRW-1:0] base;
    logic [LENW-1:0]  len;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    logic [WIDTH-1:0] memory [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    bram_read_stream #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port: word registered at the end of the addressed cycle.
    always @(posedge clk) mem_data <= memory[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            case (k % 6)
                0, 3, 5: return 1'b1;
                default: return 1'b0;
            endcase
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one burst; the expected stream is memory[(b+i) mod DEPTH], last on i == l-1.
    task automatic run_burst(input int b, input int l, input int mode, input int poke_k,
                             input bit chk_lat, input bit chk_addr, input bit chk_out);
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] e;
        int  k = 0;
        int  first_valid = 0;
        int  last_k = -1;
        int  done_k = -1;
        int  accepted = 0;
        int  issued;
        bit  prev_v = 0;
        bit  prev_r = 0;
        bit  prev_l = 0;
        logic [WIDTH-1:0] prev_d = '0;

        for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), memory[(b + i) % DEPTH]});

        @(posedge clk); #1;
        start = 1'b1; base = ADDRW'(b); len = LENW'(l); out_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0; base = ADDRW'($urandom); len = LENW'($urandom); out_ready = ready_for(mode, 1);

        for (int guard = 0; guard < l * 12 + 40; guard++) begin
            @(negedge clk);
            k++;
            if (k == 1) check("busy_after_start", busy, (l != 0));
            if (out_valid && first_valid == 0) first_valid = k;
            if (prev_v && !prev_r) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            if (chk_addr && k <= l) check("mem_addr", mem_addr, (b + k - 1) % DEPTH);
            if (chk_out && l > 0 && l < DEPTH) begin
                issued = (int'(mem_addr) - b + DEPTH) % DEPTH;
                check("outstanding", (issued - accepted) <= 2, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", out_data, e[WIDTH-1:0]);
                    check("last", out_last, e[WIDTH]);
                    if (e[WIDTH]) last_k = k;
                end
                accepted++;
            end
            if (done) begin
                done_k = k;
                check("busy_at_done", busy, 0);
                break;
            end
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
            @(posedge clk); #1;
            out_ready = ready_for(mode, k + 1);
            if (k + 1 == poke_k) begin
                start = 1'b1; base = 8'd100; len = 9'd3;
            end else begin
                start = 1'b0;
            end
        end

        check("done_seen", (done_k > 0), 1);
        if (l > 0) check("done_after_last", done_k, last_k + 1);
        else       check("done_len0_cycle", done_k, 1);
        if (l == 0) check("no_valid_len0", first_valid, 0);
        if (chk_lat) check("first_valid_latency", first_valid, 3);
        check("words_missing", exp_q.size(), 0);
        @(negedge clk);
        check("done_is_pulse", done, 0);
        check("idle_after", busy, 0);
        start = 1'b0;
    endtask

    initial begin
        int vcount;
        bit bad_done;

        for (int i = 0; i < DEPTH; i++) memory[i] = WIDTH'(i);
        rst = 1'b1; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_burst(4, 5, 0, 0, 1, 1, 1);
        run_burst(254, 4, 0, 0, 1, 1, 0);
        run_burst(0, 6, 1, 0, 0, 0, 1);
        run_burst(0, 0, 0, 0, 0, 0, 0);

        // Reset on the third data cycle of an 8-word burst.
        @(posedge clk); #1;
        start = 1'b1; base = 8'd0; len = 9'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vcount = 0;
        for (int g = 0; g < 20 && vcount < 3; g++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("reached_third_word", vcount, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        bad_done = 0;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if (done || out_valid) bad_done = 1;
        end
        check("midrst_quiet", bad_done, 0);
        run_burst(16, 2, 0, 0, 1, 1, 1);

        run_burst(20, 8, 0, 4, 1, 1, 1);
        run_burst(10, 256, 0, 0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++) memory[i] = WIDTH'($urandom);
        for (int t = 0; t < 12; t++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)),
                      (t == 5) ? 0 : int'($urandom_range(1, 40)),
                      (t % 3 == 0) ? 1 : 2, 0, 0, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_read_stream.md
Name: bram_read_stream

Overview:
- Single-clock read sequencer that sits directly downstream of the simple dual-port block RAM's read port.
- On `start`, it issues `len` sequential read addresses beginning at `base`, wrapping modulo `DEPTH`.
- It absorbs the RAM's 1-cycle read latency and presents the words as a valid/ready stream with a last flag.
- Typical consumers: line-buffer readout, sprite fetch, palette streaming.

Parameters:
- `WIDTH`, 8: data word width; must match the RAM's `WIDTH`.
- `DEPTH`, 256: RAM depth in words; `ADDRW = $clog2(DEPTH)` and `LENW = $clog2(DEPTH)+1` are derived locally, not overridable.

Ports:
- `clk`  input  1  single clock (the RAM's read clock is tied to this).
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  begin a burst; sampled only in IDLE.
- `base`  input  ADDRW  first address, sampled with `start`.
- `len`  input  LENW  word count 0..DEPTH, sampled with `start`.
- `busy`  output  1  high from the cycle after start acceptance until done.
- `done`  output  1  1-cycle pulse at burst end.
- `mem_addr`  output  ADDRW  to RAM `addr_read`.
- `mem_data`  input  WIDTH  from RAM `data_out`.
- `out_data`  output  WIDTH  stream data.
- `out_valid`  output  1  stream valid.
- `out_ready`  input  1  stream ready.
- `out_last`  output  1  qualifies the final word of the burst.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; `busy`, `done`, `out_valid`, `out_last` = 0; `mem_addr` = 0; `out_data` = 0; buffer count and in-flight flag cleared.
- States:
  - IDLE: `start` with `len > 0` goes to READ; `start` with `len == 0` pulses `done` the next cycle, with no output and `busy` staying 0.
  - READ: issues reads until `len` reads have been issued, then goes to DRAIN.
  - DRAIN: waits for the final word to be accepted, pulses `done` and returns to IDLE in the same transition.
- Read issue:
  - An issue in cycle t means `mem_addr` holds the target address during t.
  - The RAM registers the word at the end of t, so `mem_data` is valid during t+1.
  - That word is written into the internal buffer at the end of t+1.
- Address handling: `mem_addr` increments after each issue, wrapping `DEPTH-1` to 0. The address is held when no read is issued.
- Buffer: 2-entry FIFO, no bypass, so `out_data` and `out_valid` come from registers.
- Credit rule: issue in cycle t only if (buffer count + in-flight − pop_t) < 2, where pop_t = `out_valid & out_ready`. This rule guarantees no overflow and no dropped read data.
- Latency: start accepted at the end of cycle 0 → first issue in cycle 1 → `out_valid` first high in cycle 3.
- Throughput: with `out_ready` held high, one word per cycle.
- Backpressure: with `out_ready` low, `out_valid`, `out_data` and `out_last` are held stable; issue stalls once 2 credits are consumed.
- `out_last`: high exactly with the `len`-th word; a counter of LENW bits tracks issued words.
- `done`: pulses the cycle after the last-word handshake.
- `busy`: drops in the same cycle that `done` pulses.
- `start` while busy: ignored; the `base`/`len` captured at acceptance stay in force.
- Reset mid-burst: everything returns to reset values next cycle. Any in-flight RAM data is discarded and `done` is not pulsed.
- `len == DEPTH`: the full RAM is read once, ending at `base−1` mod `DEPTH`.

Decomposition:
- Package `bram_stream_pkg`:
  - typedef enum `{IDLE, READ, DRAIN}` `rs_state_t`;
  - localparam `RS_BUF_DEPTH = 2`.
- One natural sub-module: `fifo2_reg`, a 2-entry register FIFO with push/pop/count, parameterised by `WIDTH`.
  - Width carries `{last, data}`.
  - Simultaneous push and pop when full is legal; the credit rule guarantees it is never needed when full without a pop.

Test Plan:
- RAM `memory[i] = i`; start base=4, len=5, `out_ready = 1` → `out_valid` first high 3 cycles after start; data 4,5,6,7,8 on consecutive cycles; `out_last` only with 8; `done` pulses the cycle after 8 is accepted.
- Wrap: base=254, len=4, `DEPTH = 256` → data 254,255,0,1; `mem_addr` sequence 254,255,0,1.
- Backpressure: base=0, len=6; `out_ready` toggles 1,0,0,1,0,1... → data 0..5 in order with none lost or duplicated; `out_data` is stable while `valid & !ready`; at most 2 reads are outstanding beyond accepted words.
- `len = 0` → `done` pulses 1 cycle after start; `out_valid` never high; `busy` stays 0.
- `rst` asserted on the 3rd data cycle of a len=8 burst → next cycle `out_valid`, `busy` = 0; no `done`; a new start base=16, len=2 yields 16,17 only.
- Start while busy: second start (base=100) mid-burst is ignored → original sequence completes unchanged; full-depth burst len=256 from base=10 ends with `out_last` on data 9.
